// File: rtl/id_ex_decode_if.sv
// id_ex_decode_if: IF/ID-side inputs and ID/EX-side outputs of the decode stage
// slave modport: the decode stage (consumes if_*/rs*_data/stall/flush, drives ex_*)
// master modport: the surrounding pipeline (drives inputs, observes ex_*)
interface id_ex_decode_if;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        stall;
  logic        flush;
  logic        ex_valid;
  logic [3:0]  ex_alu_sel;
  logic [31:0] ex_alu_src_a;
  logic [31:0] ex_alu_src_b;
  logic [31:0] ex_rs2_data;
  logic [31:0] ex_pc;
  logic [31:0] ex_link;
  logic [4:0]  ex_rd;
  logic        ex_reg_we;
  logic        ex_mem_re;
  logic        ex_mem_we;
  logic        ex_branch;
  logic        ex_jump;
  logic [2:0]  ex_funct3;
  logic        ex_illegal;
  modport slave (
    input  if_valid, if_instr, if_pc, rs1_data, rs2_data, stall, flush,
    output ex_valid, ex_alu_sel, ex_alu_src_a, ex_alu_src_b, ex_rs2_data, ex_pc, ex_link,
           ex_rd, ex_reg_we, ex_mem_re, ex_mem_we, ex_branch, ex_jump, ex_funct3, ex_illegal
  );
  modport master (
    output if_valid, if_instr, if_pc, rs1_data, rs2_data, stall, flush,
    input  ex_valid, ex_alu_sel, ex_alu_src_a, ex_alu_src_b, ex_rs2_data, ex_pc, ex_link,
           ex_rd, ex_reg_we, ex_mem_re, ex_mem_we, ex_branch, ex_jump, ex_funct3, ex_illegal
  );
endinterface

// File: rtl/id_ex_decode.sv
// id_ex_decode: RV32I decode plus stall/flush-controlled ID/EX pipeline register
// ports: clk, rst_n (sync active-low), bus (id_ex_decode_if.slave: IF/ID inputs, ex_* outputs)
// option: ID_ILLEGAL_DETECT_EN flags undecodable instructions on ex_illegal
module id_ex_decode (
  input logic           clk,
  input logic           rst_n,
  id_ex_decode_if.slave bus
);
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;
  localparam logic [3:0] ALU_LUI  = 4'd10;
  localparam logic [3:0] ALU_JALR = 4'd11;
  typedef struct packed {
    logic        valid;
    logic [3:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] rs2;
    logic [31:0] pc;
    logic [31:0] link;
    logic [4:0]  rd;
    logic        we;
    logic        re;
    logic        mwe;
    logic        br;
    logic        jmp;
    logic [2:0]  f3;
    logic        ill;
  } ex_t;
  localparam ex_t BUB = '{alu: ALU_ADD, default: '0};
  ex_t ex_d, ex_q;
  logic        known;
  logic [31:0] in;
  logic [6:0]  op, f7;
  logic [2:0]  f3;
  logic [4:0]  rd;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign in    = bus.if_instr;
  assign op    = in[6:0];
  assign f7    = in[31:25];
  assign f3    = in[14:12];
  assign rd    = in[11:7];
  assign imm_i = {{20{in[31]}}, in[31:20]};
  assign imm_s = {{20{in[31]}}, in[31:25], in[11:7]};
  assign imm_b = {{19{in[31]}}, in[31], in[7], in[30:25], in[11:8], 1'b0};
  assign imm_u = {in[31:12], 12'b0};
  assign imm_j = {{11{in[31]}}, in[31], in[19:12], in[20], in[30:21], 1'b0};
  function automatic logic [3:0] alu_of(input logic [2:0] f, input logic alt, input logic sub_ok);
    case (f)
      3'b000:  return (alt && sub_ok) ? ALU_SUB : ALU_ADD;
      3'b001:  return ALU_SLL;
      3'b010:  return ALU_SLT;
      3'b011:  return ALU_SLTU;
      3'b100:  return ALU_XOR;
      3'b101:  return alt ? ALU_SRA : ALU_SRL;
      3'b110:  return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction
`ifdef ID_ILLEGAL_DETECT_EN
  logic bad;
  // funct7 must be 0 or 0x20, except SLLI which only allows 0; BRANCH funct3 010/011 are reserved
  assign bad = !known
             || (op == 7'b0110011 && f7 != 7'h00 && f7 != 7'h20)
             || (op == 7'b0010011 && f3 == 3'b001 && f7 != 7'h00)
             || (op == 7'b0010011 && f3 == 3'b101 && f7 != 7'h00 && f7 != 7'h20)
             || (op == 7'b1100011 && f3[2:1] == 2'b01);
`endif
  always_comb begin
    ex_d = BUB;
    known = 1'b1;
    ex_d.valid = 1'b1;
    ex_d.pc = bus.if_pc;
    ex_d.link = bus.if_pc + 32'd4;
    ex_d.rd = rd;
    ex_d.f3 = f3;
    ex_d.rs2 = bus.rs2_data;
    case (op)
      7'b0110111: begin ex_d.alu = ALU_LUI; ex_d.b = imm_u; ex_d.we = 1'b1; end
      7'b0010111: begin ex_d.a = bus.if_pc; ex_d.b = imm_u; ex_d.we = 1'b1; end
      7'b1101111: begin ex_d.a = bus.if_pc; ex_d.b = imm_j; ex_d.jmp = 1'b1; ex_d.we = 1'b1; end
      7'b1100111: begin ex_d.alu = ALU_JALR; ex_d.a = bus.rs1_data; ex_d.b = imm_i; ex_d.jmp = 1'b1; ex_d.we = 1'b1; end
      7'b1100011: begin ex_d.a = bus.if_pc; ex_d.b = imm_b; ex_d.br = 1'b1; end
      7'b0000011: begin ex_d.a = bus.rs1_data; ex_d.b = imm_i; ex_d.re = 1'b1; ex_d.we = 1'b1; end
      7'b0100011: begin ex_d.a = bus.rs1_data; ex_d.b = imm_s; ex_d.mwe = 1'b1; end
      7'b0010011: begin ex_d.alu = alu_of(f3, in[30], 1'b0); ex_d.a = bus.rs1_data; ex_d.b = imm_i; ex_d.we = 1'b1; end
      7'b0110011: begin ex_d.alu = alu_of(f3, in[30], 1'b1); ex_d.a = bus.rs1_data; ex_d.b = bus.rs2_data; ex_d.we = 1'b1; end
      default:    known = 1'b0;
    endcase
    ex_d.we = ex_d.we && rd != 5'd0;
`ifdef ID_ILLEGAL_DETECT_EN
    if (!bus.if_valid) ex_d = BUB;
    else if (bad) begin
      ex_d = BUB;
      ex_d.valid = 1'b1;
      ex_d.ill = 1'b1;
    end
`else
    if (!bus.if_valid || !known) ex_d = BUB;
`endif
  end
  always_ff @(posedge clk) begin
    if (!rst_n) ex_q <= '0;
    else if (bus.flush) ex_q <= BUB;
    else if (!bus.stall) ex_q <= ex_d;
  end
  assign bus.ex_valid     = ex_q.valid;
  assign bus.ex_alu_sel   = ex_q.alu;
  assign bus.ex_alu_src_a = ex_q.a;
  assign bus.ex_alu_src_b = ex_q.b;
  assign bus.ex_rs2_data  = ex_q.rs2;
  assign bus.ex_pc        = ex_q.pc;
  assign bus.ex_link      = ex_q.link;
  assign bus.ex_rd        = ex_q.rd;
  assign bus.ex_reg_we    = ex_q.we;
  assign bus.ex_mem_re    = ex_q.re;
  assign bus.ex_mem_we    = ex_q.mwe;
  assign bus.ex_branch    = ex_q.br;
  assign bus.ex_jump      = ex_q.jmp;
  assign bus.ex_funct3    = ex_q.f3;
  assign bus.ex_illegal   = ex_q.ill;
endmodule

// File: tb/tb_id_ex_decode.sv
// tb_id_ex_decode: directed-vector bench for id_ex_decode
module tb_id_ex_decode;
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_LUI  = 4'd10;
  localparam logic [3:0] ALU_JALR = 4'd11;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int total = 0;
  int bad = 0;
  id_ex_decode_if bus ();
  id_ex_decode dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
  always #5 clk = ~clk;
  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [31:0] r2, input logic st, input logic fl);
    bus.if_valid = v;
    bus.if_instr = ins;
    bus.if_pc = pc;
    bus.rs1_data = r1;
    bus.rs2_data = r2;
    bus.stall = st;
    bus.flush = fl;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 1'b0;
    drive(1'b1, 32'h402081B3, 32'h40, 32'd10, 32'd3, 1'b1, 1'b0);
    drive(1'b1, 32'h402081B3, 32'h40, 32'd10, 32'd3, 1'b0, 1'b1);
    total++;
    if ({bus.ex_valid, bus.ex_alu_sel, bus.ex_alu_src_a, bus.ex_alu_src_b, bus.ex_rs2_data, bus.ex_pc, bus.ex_link,
         bus.ex_rd, bus.ex_reg_we, bus.ex_mem_re, bus.ex_mem_we, bus.ex_branch, bus.ex_jump, bus.ex_funct3, bus.ex_illegal} !== '0) begin
      bad++;
      $display("FAIL reset: outputs not all zero (valid=%b alu=%0d a=%h pc=%h link=%h)", bus.ex_valid, bus.ex_alu_sel, bus.ex_alu_src_a, bus.ex_pc, bus.ex_link);
    end
    rst_n = 1'b1;
    drive(1'b1, 32'h402081B3, 32'h40, 32'd10, 32'd3, 1'b1, 1'b0);
    total++;
    if ({bus.ex_valid, bus.ex_alu_sel, bus.ex_alu_src_a, bus.ex_alu_src_b, bus.ex_link, bus.ex_rd, bus.ex_reg_we} !== '0) begin
      bad++;
      $display("FAIL reset_stall: valid=%b alu=%0d a=%h b=%h link=%h rd=%0d we=%b want all 0", bus.ex_valid, bus.ex_alu_sel, bus.ex_alu_src_a, bus.ex_alu_src_b, bus.ex_link, bus.ex_rd, bus.ex_reg_we);
    end
  endtask
  task automatic test_sub;
    drive(1'b1, 32'h402081B3, 32'h40, 32'd10, 32'd3, 1'b0, 1'b0);
    total++;
    if (bus.ex_alu_sel !== ALU_SUB) begin bad++; $display("FAIL sub_alu: got %0d want %0d", bus.ex_alu_sel, ALU_SUB); end
    total++;
    if (bus.ex_alu_src_a !== 32'd10 || bus.ex_alu_src_b !== 32'd3) begin
      bad++; $display("FAIL sub_ops: a=%h b=%h want 0000000a 00000003", bus.ex_alu_src_a, bus.ex_alu_src_b);
    end
    total++;
    if (bus.ex_rd !== 5'd3 || bus.ex_reg_we !== 1'b1 || bus.ex_valid !== 1'b1 || bus.ex_link !== 32'h44) begin
      bad++; $display("FAIL sub_ctl: rd=%0d we=%b valid=%b link=%h want 3 1 1 00000044", bus.ex_rd, bus.ex_reg_we, bus.ex_valid, bus.ex_link);
    end
  endtask
  task automatic test_srai;
    drive(1'b1, 32'h40435293, 32'h48, 32'h80000000, 32'd0, 1'b0, 1'b0);
    total++;
    if (bus.ex_alu_sel !== ALU_SRA || bus.ex_alu_src_b[4:0] !== 5'd4 || bus.ex_alu_src_a !== 32'h80000000) begin
      bad++; $display("FAIL srai: alu=%0d b=%h a=%h want %0d b[4:0]=4 80000000", bus.ex_alu_sel, bus.ex_alu_src_b, bus.ex_alu_src_a, ALU_SRA);
    end
    total++;
    if (bus.ex_rd !== 5'd5 || bus.ex_reg_we !== 1'b1) begin
      bad++; $display("FAIL srai_ctl: rd=%0d we=%b want 5 1", bus.ex_rd, bus.ex_reg_we);
    end
  endtask
  task automatic test_jalr_stall;
    drive(1'b1, 32'h008100E7, 32'h100, 32'h200, 32'h55, 1'b0, 1'b0);
    total++;
    if (bus.ex_alu_sel !== ALU_JALR || bus.ex_alu_src_a !== 32'h200 || bus.ex_alu_src_b !== 32'd8) begin
      bad++; $display("FAIL jalr_ops: alu=%0d a=%h b=%h want %0d 00000200 00000008", bus.ex_alu_sel, bus.ex_alu_src_a, bus.ex_alu_src_b, ALU_JALR);
    end
    total++;
    if (bus.ex_link !== 32'h104 || bus.ex_pc !== 32'h100 || bus.ex_jump !== 1'b1 || bus.ex_reg_we !== 1'b1 || bus.ex_rd !== 5'd1) begin
      bad++; $display("FAIL jalr_ctl: link=%h pc=%h jump=%b we=%b rd=%0d want 00000104 00000100 1 1 1", bus.ex_link, bus.ex_pc, bus.ex_jump, bus.ex_reg_we, bus.ex_rd);
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h402081B3, 32'h300 + 32'(i * 4), 32'd7, 32'd9, 1'b1, 1'b0);
      total++;
      if (bus.ex_alu_sel !== ALU_JALR || bus.ex_alu_src_a !== 32'h200 || bus.ex_alu_src_b !== 32'd8 ||
          bus.ex_link !== 32'h104 || bus.ex_rs2_data !== 32'h55 || bus.ex_jump !== 1'b1 || bus.ex_rd !== 5'd1) begin
        bad++; $display("FAIL stall_hold%0d: alu=%0d a=%h b=%h link=%h rs2=%h jump=%b rd=%0d changed", i, bus.ex_alu_sel, bus.ex_alu_src_a, bus.ex_alu_src_b, bus.ex_link, bus.ex_rs2_data, bus.ex_jump, bus.ex_rd);
      end
    end
  endtask
  task automatic test_flush_x0;
    drive(1'b1, 32'h402081B3, 32'h60, 32'd1, 32'd2, 1'b1, 1'b1);
    total++;
    if (bus.ex_valid !== 1'b0 || bus.ex_alu_sel !== ALU_ADD || bus.ex_reg_we !== 1'b0 || bus.ex_jump !== 1'b0 ||
        bus.ex_branch !== 1'b0 || bus.ex_mem_re !== 1'b0 || bus.ex_mem_we !== 1'b0 || bus.ex_alu_src_a !== 32'd0 || bus.ex_link !== 32'd0) begin
      bad++; $display("FAIL flush: valid=%b alu=%0d we=%b jump=%b a=%h link=%h want bubble", bus.ex_valid, bus.ex_alu_sel, bus.ex_reg_we, bus.ex_jump, bus.ex_alu_src_a, bus.ex_link);
    end
    drive(1'b1, 32'h00100013, 32'h64, 32'd0, 32'd0, 1'b0, 1'b0);
    total++;
    if (bus.ex_reg_we !== 1'b0 || bus.ex_valid !== 1'b1 || bus.ex_alu_src_b !== 32'd1 || bus.ex_alu_sel !== ALU_ADD) begin
      bad++; $display("FAIL x0_dest: we=%b valid=%b b=%h alu=%0d want 0 1 00000001 0", bus.ex_reg_we, bus.ex_valid, bus.ex_alu_src_b, bus.ex_alu_sel);
    end
  endtask
  task automatic test_imm_types;
    drive(1'b1, 32'hFE208CE3, 32'h1000, 32'd1, 32'd2, 1'b0, 1'b0);
    total++;
    if (bus.ex_alu_src_b !== 32'hFFFFFFF8 || bus.ex_alu_src_a !== 32'h1000 || bus.ex_branch !== 1'b1 || bus.ex_reg_we !== 1'b0) begin
      bad++; $display("FAIL branch: b=%h a=%h br=%b we=%b want fffffff8 00001000 1 0", bus.ex_alu_src_b, bus.ex_alu_src_a, bus.ex_branch, bus.ex_reg_we);
    end
    drive(1'b1, 32'hFE20AE23, 32'h1004, 32'h500, 32'hABCD, 1'b0, 1'b0);
    total++;
    if (bus.ex_alu_src_b !== 32'hFFFFFFFC || bus.ex_alu_src_a !== 32'h500 || bus.ex_mem_we !== 1'b1 ||
        bus.ex_reg_we !== 1'b0 || bus.ex_funct3 !== 3'd2 || bus.ex_rs2_data !== 32'hABCD) begin
      bad++; $display("FAIL store: b=%h a=%h mwe=%b we=%b f3=%0d rs2=%h want fffffffc 00000500 1 0 2 0000abcd", bus.ex_alu_src_b, bus.ex_alu_src_a, bus.ex_mem_we, bus.ex_reg_we, bus.ex_funct3, bus.ex_rs2_data);
    end
    drive(1'b1, 32'h123453B7, 32'hFFFFFFFC, 32'd3, 32'd4, 1'b0, 1'b0);
    total++;
    if (bus.ex_alu_sel !== ALU_LUI || bus.ex_alu_src_b !== 32'h12345000 || bus.ex_link !== 32'd0 || bus.ex_rd !== 5'd7 || bus.ex_reg_we !== 1'b1) begin
      bad++; $display("FAIL lui_wrap: alu=%0d b=%h link=%h rd=%0d we=%b want %0d 12345000 00000000 7 1", bus.ex_alu_sel, bus.ex_alu_src_b, bus.ex_link, bus.ex_rd, bus.ex_reg_we, ALU_LUI);
    end
    drive(1'b0, 32'h402081B3, 32'h2000, 32'd1, 32'd2, 1'b0, 1'b0);
    total++;
    if (bus.ex_valid !== 1'b0 || bus.ex_reg_we !== 1'b0 || bus.ex_alu_src_a !== 32'd0 || bus.ex_pc !== 32'd0) begin
      bad++; $display("FAIL invalid_slot: valid=%b we=%b a=%h pc=%h want bubble", bus.ex_valid, bus.ex_reg_we, bus.ex_alu_src_a, bus.ex_pc);
    end
  endtask
  task automatic test_illegal;
    drive(1'b1, 32'hFFFFFFFF, 32'h3000, 32'd1, 32'd2, 1'b0, 1'b0);
`ifdef ID_ILLEGAL_DETECT_EN
    total++;
    if (bus.ex_illegal !== 1'b1 || bus.ex_valid !== 1'b1 || bus.ex_reg_we !== 1'b0 || bus.ex_jump !== 1'b0) begin
      bad++; $display("FAIL illegal: ill=%b valid=%b we=%b jump=%b want 1 1 0 0", bus.ex_illegal, bus.ex_valid, bus.ex_reg_we, bus.ex_jump);
    end
`else
    total++;
    if (bus.ex_valid !== 1'b0 || bus.ex_illegal !== 1'b0 || bus.ex_reg_we !== 1'b0) begin
      bad++; $display("FAIL illegal: valid=%b ill=%b we=%b want 0 0 0", bus.ex_valid, bus.ex_illegal, bus.ex_reg_we);
    end
`endif
  endtask
  initial begin
    test_reset;
    test_sub;
    test_srai;
    test_jalr_stall;
    test_flush_x0;
    test_imm_types;
    test_illegal;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/id_ex_decode.md
# id_ex_decode

Decode stage plus ID/EX pipeline register of the 5-stage core. It takes a fetched RV32I instruction and its register-file read data, and produces the EX-stage ALU opcode and operands, immediates and control bits. It holds all of these in a stall/flush-controlled register, so the EX-stage ALU receives `alu_sel`, `alu_src_a` and `alu_src_b` one cycle after the instruction is presented.

## Interface
- No parameters; ALU opcodes are the `ALU_*` codes from the shared ALU define header.
- clk  in  1  core clock; all state updates on rising edge
- rst_n  in  1  synchronous, active-low reset
- if_valid  in  1  IF/ID slot holds a real instruction
- if_instr  in  32  instruction word
- if_pc  in  32  instruction address
- rs1_data  in  32  register-file read of instr[19:15]
- rs2_data  in  32  register-file read of instr[24:20]
- stall  in  1  hold ID/EX contents (hazard unit)
- flush  in  1  squash: load a bubble (branch redirect)
- ex_valid  out  1  ID/EX holds a real instruction
- ex_alu_sel  out  4  ALU opcode
- ex_alu_src_a  out  32  ALU operand A
- ex_alu_src_b  out  32  ALU operand B
- ex_rs2_data  out  32  store data / branch compare operand
- ex_pc, ex_link  out  32 each  instruction PC; PC+4
- ex_rd  out  5  destination register
- ex_reg_we, ex_mem_re, ex_mem_we, ex_branch, ex_jump  out  1 each  control
- ex_funct3  out  3  load/store width, branch condition
- ex_illegal  out  1  undecodable instruction (only with macro)

## Operation
- Immediates are sign-extended to 32 bits: I, S, B (bit0=0), U (low 12 zero), J (bit0=0).
- LUI: `ALU_LUI`, B=U-imm, we=1.
- AUIPC: `ALU_ADD`, A=pc, B=U-imm, we=1.
- JAL: `ALU_ADD`, A=pc, B=J-imm, jump=1, we=1.
- JALR: `ALU_JALR`, A=rs1, B=I-imm, jump=1, we=1.
- BRANCH: `ALU_ADD`, A=pc, B=B-imm, branch=1, we=0.
- LOAD: `ALU_ADD`, A=rs1, B=I-imm, mem_re=1, we=1.
- STORE: `ALU_ADD`, A=rs1, B=S-imm, mem_we=1, we=0.
- OP-IMM: A=rs1, B=I-imm. funct3 maps ADD/SLL/SLT/SLTU/XOR/SRL-or-SRA/OR/AND. Shifts use instr[30] to pick SRA; for shifts B=imm as encoded (ALU uses [4:0]).
- OP: A=rs1, B=rs2. funct3=000 selects `ALU_SUB` when instr[30]=1, else `ALU_ADD`.
- rd=0 forces we=0.
- Any other opcode, or if_valid=0: bubble — all control bits 0, alu_sel=`ALU_ADD`, data fields 0.

## Timing
- Single-cycle latency: decode of cycle N inputs is visible on ex_* after the cycle-N edge.
- Per-edge priority: reset > flush > stall > load.
- Reset (rst_n=0 at edge): every output 0 (ex_alu_sel=0, ex_valid=0). Reset mid-stall or mid-flush wins.
- flush=1: bubble loaded regardless of stall.
- stall=1, flush=0: all ex_* hold their previous values exactly; inputs are ignored.
- Otherwise: decoded values are loaded; ex_valid=if_valid.
- ex_link = pc+4 wraps modulo 2^32 (pc=32'hFFFFFFFC gives 0).

## Configuration
- `ID_ILLEGAL_DETECT_EN` defined:
  - Unknown opcodes are flagged, as are OP funct7 not 0000000/0100000, shift funct7 illegal, and BRANCH funct3 010/011.
  - A flagged instruction loads ex_illegal=1 and ex_valid=1, with all other control bits 0.
- Not defined:
  - ex_illegal is tied 0.
  - Unknown instructions load a bubble (ex_valid=0).

## Test plan
- Reset: rst_n=0 for 2 cycles with any inputs -> all outputs 0. Release with stall=1 -> outputs stay 0.
- SUB: `sub x3,x1,x2` (32'h402081B3), rs1=10, rs2=3 -> next cycle ALU_SUB, A=10, B=3, rd=3, we=1.
- SRAI: `srai x5,x6,4` (32'h40435293), rs1=32'h80000000 -> ALU_SRA, B[4:0]=4.
- JALR then stall: `jalr x1,8(x2)` at pc=32'h100, rs1=32'h200 -> ALU_JALR, A=32'h200, B=8, link=32'h104, jump=1. Stall 3 cycles with new instructions presented -> outputs unchanged.
- Flush during stall, then x0 destination:
  - Stall=1 and flush=1 together -> ex_valid=0, all control 0.
  - `addi x0,x0,1` -> we=0.
- Illegal opcode 32'hFFFFFFFF:
  - With macro -> ex_illegal=1, ex_valid=1.
  - Without macro -> ex_valid=0.
